// File: rtl/tc_cmd_receiver.sv
// TinyComp command receiver: buffers LastALU words in a FIFO, decodes them and
// issues up to two DDR operations per word over a valid/ready handshake.
module tc_cmd_receiver #(
    parameter int DEPTH     = 8,
    parameter int RANK_BITS = 1
) (
    input  logic                   Ph0,
    input  logic                   Reset,
    input  logic [33:0]            LastALU,
    input  logic                   injectTC5address,
    input  logic                   InhibitDDR,
    input  logic                   ClearErr,
    output logic                   cmdValid,
    input  logic                   cmdReady,
    output logic [2:0]             cmdOut,
    output logic [2:0]             bankOut,
    output logic [13:0]            rowOut,
    output logic [13:0]            colOut,
    output logic [RANK_BITS-1:0]   rankOut,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifoCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRI  = 2'd1;
    localparam logic [1:0] S_ALT  = 2'd2;

    logic [33:0]          mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [1:0]           state;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 accept;

    logic [33:0]          head;
    logic [2:0]           head_cmd;
    logic [2:0]           head_alt;
    logic [2:0]           head_bank;
    logic [13:0]          head_row;
    logic [13:0]          head_col;
    logic [RANK_BITS-1:0] head_rank;
    logic                 unused_bits;

    assign head      = mem[rd_ptr];
    assign head_cmd  = head[30:28];
    assign head_alt  = head[33:31];
    assign head_bank = head[11:9];
    assign head_row  = head[25:12];
    assign head_col  = {4'b0, head[7:0], 2'b0};
    assign head_rank = head[26 +: RANK_BITS];
    assign unused_bits = ^{head[8], head[33:26]};

    assign full   = (fifoCount == FULL_COUNT);
    assign empty  = (fifoCount == '0);
    assign accept = cmdValid & cmdReady;

    // An entry leaves the FIFO once its last operation is accepted, or at once
    // when it carries no operation at all.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = !empty && !InhibitDDR && (head_cmd == 3'd0) && (head_alt == 3'd0);
            S_PRI:   pop = accept && (head_alt == 3'd0);
            S_ALT:   pop = accept;
            default: pop = 1'b0;
        endcase
    end

    // A full FIFO still takes a word when the head leaves at the same edge.
    assign push = injectTC5address && (!full || pop);

    always_ff @(posedge Ph0) begin
        if (push) begin
            mem[wr_ptr] <= LastALU;
        end
    end

    always_ff @(posedge Ph0 or negedge Reset) begin
        if (!Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
            if (injectTC5address && !push) begin
                overflow <= 1'b1;
            end else if (ClearErr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Operation outputs are registered; they only change on an accept or when
    // a new entry is started, so they stay stable under backpressure.
    always_ff @(posedge Ph0 or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cmdValid <= 1'b0;
            cmdOut   <= '0;
            bankOut  <= '0;
            rowOut   <= '0;
            colOut   <= '0;
            rankOut  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty && !InhibitDDR) begin
                        if (head_cmd != 3'd0) begin
                            state    <= S_PRI;
                            cmdValid <= 1'b1;
                            cmdOut   <= head_cmd;
                            bankOut  <= head_bank;
                            rowOut   <= head_row;
                            rankOut  <= head_rank;
                            colOut   <= '0;
                        end else if (head_alt != 3'd0) begin
                            state    <= S_ALT;
                            cmdValid <= 1'b1;
                            cmdOut   <= head_alt;
                            bankOut  <= head_bank;
                            rowOut   <= head_row;
                            rankOut  <= head_rank;
                            colOut   <= head_col;
                        end
                    end
                end
                S_PRI: begin
                    if (accept) begin
                        if (head_alt != 3'd0) begin
                            state  <= S_ALT;
                            cmdOut <= head_alt;
                            colOut <= head_col;
                        end else begin
                            state    <= S_IDLE;
                            cmdValid <= 1'b0;
                        end
                    end
                end
                S_ALT: begin
                    if (accept) begin
                        state    <= S_IDLE;
                        cmdValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cmdValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_cmd_receiver.sv
// Randomized bench for tc_cmd_receiver: a queue-based model predicts the
// operation stream, FIFO occupancy and overflow flag every cycle.
module tb_tc_cmd_receiver;

    localparam int DEPTH = 8;
    localparam int RB    = 1;
    localparam logic [33:0] TEST_WORD =
        {3'b010, 3'b001, 1'b0, 1'b1, 14'h1A5, 3'b101, 1'b0, 8'h3C};

    logic        Ph0;
    logic        Reset;
    logic [33:0] LastALU;
    logic        injectTC5address;
    logic        InhibitDDR;
    logic        ClearErr;
    logic        cmdValid;
    logic        cmdReady;
    logic [2:0]  cmdOut;
    logic [2:0]  bankOut;
    logic [13:0] rowOut;
    logic [13:0] colOut;
    logic [RB-1:0] rankOut;
    logic        overflow;
    logic [$clog2(DEPTH):0] fifoCount;

    int checks;
    int errors;

    logic [33:0] mq[$];
    int          m_done;
    bit          m_valid;
    bit          m_ovf;

    tc_cmd_receiver #(.DEPTH(DEPTH), .RANK_BITS(RB)) dut (
        .Ph0(Ph0),
        .Reset(Reset),
        .LastALU(LastALU),
        .injectTC5address(injectTC5address),
        .InhibitDDR(InhibitDDR),
        .ClearErr(ClearErr),
        .cmdValid(cmdValid),
        .cmdReady(cmdReady),
        .cmdOut(cmdOut),
        .bankOut(bankOut),
        .rowOut(rowOut),
        .colOut(colOut),
        .rankOut(rankOut),
        .overflow(overflow),
        .fifoCount(fifoCount)
    );

    initial Ph0 = 1'b0;
    always #5 Ph0 = ~Ph0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Number of DDR operations a word produces: one per non-zero code.
    function automatic int nOps(input logic [33:0] w);
        return int'(w[30:28] != 3'd0) + int'(w[33:31] != 3'd0);
    endfunction

    task automatic modelClear();
        mq.delete();
        m_done  = 0;
        m_valid = 0;
        m_ovf   = 0;
    endtask

    task automatic checkModel();
        logic [33:0] w;
        logic [2:0]  ecmd;
        logic [13:0] ecol;
        checkOutput("valid", 64'(cmdValid), 64'(m_valid));
        checkOutput("count", 64'(fifoCount), 64'(mq.size()));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        if (m_valid && mq.size() > 0) begin
            w = mq[0];
            if (m_done == 0 && w[30:28] != 3'd0) begin
                ecmd = w[30:28];
                ecol = 14'd0;
            end else begin
                ecmd = w[33:31];
                ecol = {4'b0, w[7:0], 2'b0};
            end
            checkOutput("cmd", 64'(cmdOut), 64'(ecmd));
            checkOutput("row", 64'(rowOut), 64'(w[25:12]));
            checkOutput("bank", 64'(bankOut), 64'(w[11:9]));
            checkOutput("rank", 64'(rankOut), 64'(w[26 +: RB]));
            checkOutput("col", 64'(colOut), 64'(ecol));
        end
    endtask

    // One clock cycle: drive inputs, predict the edge, then compare on the falling edge.
    task automatic applyStimulus(input bit inj, input logic [33:0] word, input bit inh,
                                 input bit clr, input bit rdy);
        bit pop;
        bit push;
        bit nv;
        int nd;
        injectTC5address = inj;
        LastALU          = word;
        InhibitDDR       = inh;
        ClearErr         = clr;
        cmdReady         = rdy;
        pop = 0;
        nv  = m_valid;
        nd  = m_done;
        if (m_valid) begin
            if (rdy) begin
                if (m_done + 1 >= nOps(mq[0])) begin
                    pop = 1;
                    nv  = 0;
                    nd  = 0;
                end else begin
                    nd = m_done + 1;
                end
            end
        end else if (!inh && mq.size() > 0) begin
            if (nOps(mq[0]) == 0) pop = 1;
            else nv = 1;
        end
        push = inj && (mq.size() < DEPTH || pop);
        @(posedge Ph0);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(word);
        if (inj && !push) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_valid = nv;
        m_done  = nd;
        @(negedge Ph0);
        checkModel();
    endtask

    function automatic logic [33:0] randWord(input bit both_nonzero);
        logic [33:0] w;
        w = {$urandom(), 2'($urandom())};
        if (both_nonzero) begin
            w[30:28] = 3'($urandom_range(1, 7));
            w[33:31] = 3'($urandom_range(1, 7));
        end else if ($urandom_range(0, 7) == 0) begin
            w[33:28] = 6'd0;
        end
        return w;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        modelClear();
        Reset = 1'b0;
        LastALU = '0;
        injectTC5address = 0;
        InhibitDDR = 0;
        ClearErr = 0;
        cmdReady = 0;
        repeat (3) @(negedge Ph0);
        checkOutput("rst_valid", 64'(cmdValid), 64'd0);
        checkOutput("rst_cmd", 64'(cmdOut), 64'd0);
        checkOutput("rst_row", 64'(rowOut), 64'd0);
        checkOutput("rst_col", 64'(colOut), 64'd0);
        checkOutput("rst_bank", 64'(bankOut), 64'd0);
        checkOutput("rst_rank", 64'(rankOut), 64'd0);
        checkOutput("rst_count", 64'(fifoCount), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        Reset = 1'b1;

        $display("[TB] single word");
        applyStimulus(1, TEST_WORD, 0, 0, 1);
        checkOutput("single_k_valid", 64'(cmdValid), 64'd0);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("single_pri_valid", 64'(cmdValid), 64'd1);
        checkOutput("single_pri_cmd", 64'(cmdOut), 64'd1);
        checkOutput("single_pri_row", 64'(rowOut), 64'h1A5);
        checkOutput("single_pri_bank", 64'(bankOut), 64'd5);
        checkOutput("single_pri_rank", 64'(rankOut), 64'd1);
        checkOutput("single_pri_col", 64'(colOut), 64'd0);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("single_alt_cmd", 64'(cmdOut), 64'd2);
        checkOutput("single_alt_col", 64'(colOut), 64'h0F0);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("single_done_valid", 64'(cmdValid), 64'd0);

        $display("[TB] backpressure");
        applyStimulus(1, TEST_WORD, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 0, 0);
        checkOutput("bp_cmd", 64'(cmdOut), 64'd1);
        checkOutput("bp_count", 64'(fifoCount), 64'd1);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("bp_alt_cmd", 64'(cmdOut), 64'd2);
        applyStimulus(0, '0, 0, 0, 1);

        $display("[TB] zero codes");
        applyStimulus(1, 34'h0_0ABC_DEF1 & 34'h0_0FFF_FFFF, 0, 0, 1);
        checkOutput("zero_count1", 64'(fifoCount), 64'd1);
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("zero_count0", 64'(fifoCount), 64'd0);
        checkOutput("zero_valid", 64'(cmdValid), 64'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 9; i++) applyStimulus(1, randWord(0), 1, 0, 1);
        checkOutput("ovf_count", 64'(fifoCount), 64'd8);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 30; i++) applyStimulus(0, '0, 0, 0, 1);
        checkOutput("ovf_drain", 64'(fifoCount), 64'd0);
        applyStimulus(0, '0, 0, 1, 1);
        checkOutput("ovf_clear", 64'(overflow), 64'd0);

        $display("[TB] full with pop");
        for (int i = 0; i < 8; i++) applyStimulus(1, randWord(1), 1, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(1, randWord(1), 0, 0, 1);
        checkOutput("fwp_count", 64'(fifoCount), 64'd8);
        checkOutput("fwp_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 30; i++) applyStimulus(0, '0, 0, 0, 1);

        $display("[TB] reset mid-operation");
        applyStimulus(1, TEST_WORD, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        cmdReady = 0;
        #2 Reset = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(cmdValid), 64'd0);
        checkOutput("arst_count", 64'(fifoCount), 64'd0);
        modelClear();
        @(negedge Ph0);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, 0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 9) < 4, randWord(0),
                          $urandom_range(0, 19) < 3, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 40; i++) applyStimulus(0, '0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_cmd_receiver.md
Name: tc_cmd_receiver

Overview:
- Memory-controller end of the TinyComp command interface.
- Captures each 34-bit LastALU word qualified by the one-cycle injectTC5address strobe and buffers it in a small FIFO.
- Decodes the word into bank/row/col/rank/cmd/altCmd fields.
- Issues up to two DDR operations per word (primary cmd, then altCmd) to the DDR command pipe over a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- RANK_BITS, 1, rank field width: 1 for XUPv5 (bit 26), 2 for BEE3 (bits 27:26).

Ports:
- Ph0  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LastALU  in  34  command word from TinyComp.
- injectTC5address  in  1  one-cycle strobe; LastALU is valid in the same cycle.
- InhibitDDR  in  1  when high, no new operation is started; the FIFO keeps filling.
- ClearErr  in  1  clears the overflow flag.
- cmdValid  out  1  operation on the cmd* outputs is valid.
- cmdReady  in  1  DDR pipe accepts the operation.
- cmdOut  out  3  DDR command code; 0 = no-op, never issued.
- bankOut  out  3  bank.
- rowOut  out  14  row address.
- colOut  out  14  column address.
- rankOut  out  RANK_BITS  rank.
- overflow  out  1  sticky: a word was dropped.
- fifoCount  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Field decode, per FIFO entry:
  - col = {4'b0, LastALU[7:0], 2'b0}
  - bank = [11:9]
  - row = [25:12]
  - rank = [26 +: RANK_BITS]
  - cmd = [30:28]
  - altCmd = [33:31]
  - Bit 8 is ignored.
- Reset (async assert, sync release): FIFO empty, state IDLE. Outputs reset to: cmdValid=0, cmdOut=0, bankOut=0, rowOut=0, colOut=0, rankOut=0, overflow=0, fifoCount=0.
- Push: when injectTC5address=1 at an edge, the word is written if the FIFO is not full, or if it is full and a pop occurs at the same edge.
  - Otherwise the word is dropped and overflow is set.
  - If injection and ClearErr coincide, set wins.
- State machine (states IDLE, PRI, ALT):
  - IDLE, with FIFO non-empty and InhibitDDR=0:
    - Head cmd≠0 → PRI. Registered outputs load cmdOut=cmd, row/bank/rank, colOut=0; cmdValid=1.
    - Else head altCmd≠0 → ALT. Outputs load cmdOut=altCmd, row/bank/rank, colOut=col.
    - Else (both 0) → the entry is popped silently and the FSM stays in IDLE.
  - PRI, on cmdValid&cmdReady:
    - altCmd≠0 → ALT; outputs reload with altCmd and col at the same edge, cmdValid stays 1 (back-to-back).
    - Else → entry popped, cmdValid=0, → IDLE.
  - ALT, on cmdValid&cmdReady: entry popped, cmdValid=0, → IDLE.
- Handshake:
  - While cmdValid=1 and cmdReady=0, all cmd* outputs are held stable.
  - InhibitDDR does not withdraw an operation already presented.
- Latency: word injected at edge k into an empty FIFO with idle FSM produces cmdValid=1 after edge k+1.
- Throughput: one entry per 2 cycles minimum (IDLE→issue), or 3 cycles when altCmd is present, with cmdReady tied high.
- fifoCount updates at the same edge as push/pop; a simultaneous push and pop leaves it unchanged.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Single word: LastALU={3'b010,3'b001,1'b0,1'b1,14'h1A5,3'b101,1'b0,8'h3C}, cmdReady=1 → cycle k+1 issues cmd=1,row=0x1A5,bank=5,rank=1,col=0; cycle k+2 issues cmd=2,col=0x0F0; cycle k+3 cmdValid=0.
- Backpressure: cmdReady=0 for 5 cycles during PRI → outputs constant, no pop, fifoCount=1; when cmdReady rises, ALT follows on the next cycle.
- Both codes zero: inject word with cmd=0, altCmd=0 → no cmdValid, fifoCount returns to 0 after 1 cycle.
- Overflow: InhibitDDR=1, 9 injections with DEPTH=8 → fifoCount=8, overflow=1. Then release → exactly 8 words issued in order. ClearErr → overflow=0.
- Full-with-pop: FIFO full and the final entry's ALT is accepted at the same edge as an injection → word kept, fifoCount stays 8, overflow=0.
- Reset mid-operation: assert Reset during ALT with cmdReady=0 → cmdValid=0 and fifoCount=0 immediately (asynchronous); after release, no stale operation is issued.
